// File: rtl/ds_pkg.sv
// Shared constants and state encoding for the DeltaSigma sample scheduler.
`timescale 1ns / 1ps
package ds_pkg;

    localparam int DS_DATA_W = 14;
    localparam logic [DS_DATA_W-1:0] DS_MID = 14'h2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ds_state_e;

endpackage

// File: rtl/ds_sample_scheduler_if.sv
// Valid/ready sample stream into the scheduler FIFO.
`timescale 1ns / 1ps
interface ds_sample_scheduler_if
    import ds_pkg::*;
#(
    parameter int DATA_W = DS_DATA_W
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/ds_sample_fifo.sv
// Sample FIFO with flush, level and first-word-fall-through head.
`timescale 1ns / 1ps
module ds_sample_fifo #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = level == LVL_W'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Storage is not reset; contents are meaningless once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/ds_sample_scheduler.sv
// Paces FIFO samples to the DeltaSigma modulator, one every OSR clocks.
// Define DS_SCHED_UNDERFLOW_CNT_EN to add the saturating underflow_count.
`timescale 1ns / 1ps
module ds_sample_scheduler
    import ds_pkg::*;
#(
    parameter int DATA_W      = DS_DATA_W,
    parameter int OSR         = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    ds_sample_scheduler_if.slave        s_if,
    output logic [DATA_W-1:0]           ds_data,
    output logic                        ds_strobe,
    output logic [1:0]                  state,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    input  logic                        clr_underflow
`ifdef DS_SCHED_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                 underflow_count
`endif
);

    localparam int TICK_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [LVL_W-1:0]  PRIME_LVL = LVL_W'(PRIME_LEVEL);
    localparam logic [DATA_W-1:0] MID       = DATA_W'(DS_MID);

    ds_state_e         st;
    logic [TICK_W-1:0] tick;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              stop;
    logic              slot;
    logic              uf_ev;

    assign state        = st;
    assign s_if.s_ready = !full;
    assign push         = s_if.s_valid && !full;
    assign stop         = !enable && (st != ST_IDLE);
    assign slot         = (st == ST_RUN) && enable && (tick == '0);
    assign pop          = slot && !empty;
    assign uf_ev        = slot && empty;

    ds_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (stop),
        .wr_data (s_if.s_data),
        .head    (head),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            tick      <= '0;
            ds_data   <= MID;
            ds_strobe <= 1'b0;
        end else begin
            ds_strobe <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    ds_data <= MID;
                    tick    <= '0;
                    if (enable) st <= ST_PRIME;
                end
                ST_PRIME: begin
                    if (stop) begin
                        st      <= ST_IDLE;
                        ds_data <= MID;
                    end else if (fifo_level >= PRIME_LVL) begin
                        st   <= ST_RUN;
                        tick <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        st      <= ST_IDLE;
                        ds_data <= MID;
                    end else begin
                        tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
                        if (pop) begin
                            ds_data   <= head;
                            ds_strobe <= 1'b1;
                        end else if (uf_ev) begin
                            st <= ST_PRIME;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // A fresh underflow outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underflow <= 1'b0;
        else if (uf_ev)
            underflow <= 1'b1;
        else if (clr_underflow)
            underflow <= 1'b0;
    end

`ifdef DS_SCHED_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_count <= '0;
        end else if (uf_ev) begin
            if (underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 1'b1;
        end else if (clr_underflow) begin
            underflow_count <= '0;
        end
    end
`endif

endmodule
